// File: rtl/dual_port_fifo.sv
// Synchronous FIFO on a registered-read dual-port array with occupancy count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module dual_port_fifo #(
  parameter int unsigned data_width = 32,
  parameter int unsigned addr_width = 4,
  parameter int unsigned mem_depth  = 16,
  parameter int unsigned af_level   = 14,
  parameter int unsigned ae_level   = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [data_width-1:0] data_in_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic                  err_clr_i,
  output logic [data_width-1:0] data_out_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [addr_width:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int unsigned CW = addr_width + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(mem_depth);
  localparam logic [CW-1:0] AF_C    = CW'(af_level);
  localparam logic [CW-1:0] AE_C    = CW'(ae_level);

  logic [data_width-1:0] mem_q [mem_depth];

  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [data_width-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  rd_acc, wr_acc;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write.
  assign rd_acc = re_i && !empty_q;
  assign wr_acc = we_i && (!full_q || rd_acc);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - 1'b1;
    end

    // Flags track the next count so they never lag count_o.
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
    ovf_d   = (ovf_q && !err_clr_i) || (we_i && !wr_acc);
    unf_d   = (unf_q && !err_clr_i) || (re_i && !rd_acc);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage is not reset; a read of the address being written returns the old word.
  always_ff @(posedge clk_i) begin
    if (!reset_i && wr_acc) begin
      mem_q[wr_ptr_q] <= data_in_i;
    end
  end

  assign data_out_o     = data_out_q;
  assign rd_valid_o     = rd_valid_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule
